// File: rtl/umbral_alarma.sv
// rtl/umbral_alarma.sv - hysteresis debouncer for the A>=B comparator result, with rise-event counter
// Optional macro UMBRAL_LATCH_EN: alarm latches once raised and is released only by clear.
module umbral_alarma #(
    parameter int ON_COUNT  = 3,
    parameter int OFF_COUNT = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             ge,
    input  logic             clear,
    output logic             alarm,
    output logic             rise,
    output logic [CNT_W-1:0] events,
    output logic [3:0]       run_len
);

    typedef enum logic [1:0] {
        S_OFF,
        S_ARM,
        S_ON,
        S_REL
    } state_t;

    localparam logic [3:0] ON_C  = 4'(ON_COUNT);
    localparam logic [3:0] OFF_C = 4'(OFF_COUNT);

`ifdef UMBRAL_LATCH_EN
    localparam bit LATCH_MODE = 1'b1;
`else
    localparam bit LATCH_MODE = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [3:0]       run_d;
    logic [3:0]       run_inc;
    logic             alarm_d;
    logic             rise_d;
    logic [CNT_W-1:0] events_d;
    logic             latched;

    assign run_inc = run_len + 4'd1;
    assign latched = LATCH_MODE && (state_q == S_ON || state_q == S_REL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_OFF;
            run_len <= 4'd0;
            alarm   <= 1'b0;
            rise    <= 1'b0;
            events  <= '0;
        end else begin
            state_q <= state_d;
            run_len <= run_d;
            alarm   <= alarm_d;
            rise    <= rise_d;
            events  <= events_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        run_d    = run_len;
        rise_d   = 1'b0;
        events_d = events;

        // A latched alarm is released only by clear, which overrides the sample
        if (clear && latched) begin
            state_d = S_OFF;
            run_d   = 4'd0;
        end else if (valid) begin
            case (state_q)
                S_OFF: begin
                    if (ge) begin
                        if (ON_C == 4'd1) begin
                            state_d = S_ON;
                            run_d   = 4'd0;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = S_ARM;
                            run_d   = 4'd1;
                        end
                    end
                end
                S_ARM: begin
                    if (!ge) begin
                        state_d = S_OFF;
                        run_d   = 4'd0;
                    end else if (run_inc == ON_C) begin
                        state_d = S_ON;
                        run_d   = 4'd0;
                        rise_d  = 1'b1;
                    end else begin
                        run_d = run_inc;
                    end
                end
                S_ON: begin
                    if (!ge && !LATCH_MODE) begin
                        if (OFF_C == 4'd1) begin
                            state_d = S_OFF;
                            run_d   = 4'd0;
                        end else begin
                            state_d = S_REL;
                            run_d   = 4'd1;
                        end
                    end
                end
                S_REL: begin
                    if (ge) begin
                        state_d = S_ON;
                        run_d   = 4'd0;
                    end else if (run_inc == OFF_C) begin
                        state_d = S_OFF;
                        run_d   = 4'd0;
                    end else begin
                        run_d = run_inc;
                    end
                end
                default: begin
                    state_d = S_OFF;
                    run_d   = 4'd0;
                end
            endcase
        end

        alarm_d = (state_d == S_ON) || (state_d == S_REL);

        // clear beats a coincident rise: that rise is not counted
        if (clear) begin
            events_d = '0;
        end else if (rise_d && (events != {CNT_W{1'b1}})) begin
            events_d = events + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_umbral_alarma.sv
// tb/tb_umbral_alarma.sv - self-checking bench for umbral_alarma against a streak-counting reference model
module tb_umbral_alarma;

    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int W   = 2;
    localparam int MAXEV = (1 << W) - 1;

`ifdef UMBRAL_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid = 1'b0;
    logic         ge = 1'b0;
    logic         clear = 1'b0;
    logic         alarm;
    logic         rise;
    logic [W-1:0] events;
    logic [3:0]   run_len;

    umbral_alarma #(.ON_COUNT(ON), .OFF_COUNT(OFF), .CNT_W(W)) dut (
        .clk(clk),
        .rst(rst),
        .valid(valid),
        .ge(ge),
        .clear(clear),
        .alarm(alarm),
        .rise(rise),
        .events(events),
        .run_len(run_len)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: alarm level plus the length of the current run of samples opposing it
    int m_alarm, m_streak, m_events, m_rise;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_alarm = 0; m_streak = 0; m_events = 0; m_rise = 0;
    endtask

    task automatic model_beat(input bit v, input bit g, input bit c);
        int thr;
        m_rise = 0;
        if (LATCH && c && m_alarm == 1) begin
            m_alarm = 0; m_streak = 0; m_events = 0;
            return;
        end
        if (v) begin
            if (LATCH && m_alarm == 1) begin
                m_streak = 0;
            end else if (int'(g) != m_alarm) begin
                m_streak++;
                thr = (m_alarm == 1) ? OFF : ON;
                if (m_streak == thr) begin
                    m_alarm = 1 - m_alarm;
                    m_streak = 0;
                    if (m_alarm == 1) begin
                        m_rise = 1;
                        if (m_events < MAXEV) m_events++;
                    end
                end
            end else begin
                m_streak = 0;
            end
        end
        if (c) m_events = 0;
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".alarm"}, int'(alarm), m_alarm);
        chk({ctx, ".rise"}, int'(rise), m_rise);
        chk({ctx, ".events"}, int'(events), m_events);
        chk({ctx, ".run_len"}, int'(run_len), m_streak);
    endtask

    task automatic step(input bit v, input bit g, input bit c, input string ctx);
        valid = v; ge = g; clear = c;
        @(posedge clk);
        model_beat(v, g, c);
        #1;
        check_all(ctx);
        valid = 1'b0; clear = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit v, g, c;
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Arm: three consecutive true samples
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, "arm");
        chk("arm_alarm", int'(alarm), 1);
        step(1'b0, 1'b1, 1'b0, "arm_idle");

        // Broken arm from a clean reset
        do_reset();
        begin
            bit pat[6] = '{1, 1, 0, 1, 1, 1};
            for (int i = 0; i < 6; i++) step(1'b1, pat[i], 1'b0, "broken");
        end
        chk("broken_alarm", int'(alarm), 1);

        // Gaps: only valid beats count
        do_reset();
        begin
            bit vp[6] = '{1, 0, 0, 1, 0, 1};
            for (int i = 0; i < 6; i++) step(vp[i], 1'b1, 1'b0, "gaps");
        end
        chk("gaps_alarm", int'(alarm), 1);

`ifndef UMBRAL_LATCH_EN
        // Hysteresis release with a bounce back to ON
        begin
            bit hp[4] = '{0, 1, 0, 0};
            for (int i = 0; i < 4; i++) step(1'b1, hp[i], 1'b0, "hyst");
        end
        chk("hyst_alarm", int'(alarm), 0);

        // Saturation, then clear coinciding with a rise
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < ON; i++) step(1'b1, 1'b1, 1'b0, "sat_on");
            for (int i = 0; i < OFF; i++) step(1'b1, 1'b0, 1'b0, "sat_off");
        end
        chk("sat_events", int'(events), MAXEV);
        step(1'b1, 1'b1, 1'b0, "sat6");
        step(1'b1, 1'b1, 1'b0, "sat6");
        step(1'b1, 1'b1, 1'b1, "sat6_clear");
        chk("clear_events", int'(events), 0);
        chk("clear_rise", int'(rise), 1);
`else
        // Latched alarm ignores false samples until clear
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, "latch_hold");
        chk("latch_alarm", int'(alarm), 1);
        step(1'b0, 1'b0, 1'b1, "latch_clear");
        chk("latch_clr_alarm", int'(alarm), 0);
        chk("latch_clr_events", int'(events), 0);
`endif

        // Async reset mid-ARM discards the partial run
        do_reset();
        step(1'b1, 1'b1, 1'b0, "pre_rst");
        step(1'b1, 1'b1, 1'b0, "pre_rst");
        do_reset();
        step(1'b1, 1'b1, 1'b0, "post_rst");

        // Randomized run
        for (int i = 0; i < 400; i++) begin
            v = ($urandom % 4) != 0;
            g = (i % 40 < 20) ? (($urandom % 5) != 0) : (($urandom % 5) == 0);
            c = ($urandom % 20) == 0;
            step(v, g, c, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/umbral_alarma.md
Name: umbral_alarma

Overview:
- Sequential stage directly downstream of the 4-bit "A >= B" comparator. Consumes its 1-bit result D, sampled under a valid strobe.
- Debounces D with hysteresis: an alarm is raised only after ON_COUNT consecutive valid "true" samples. It is dropped only after OFF_COUNT consecutive valid "false" samples.
- Counts alarm-rise events for the front-panel display logic.

Parameters:
- ON_COUNT, 3, consecutive valid ge=1 samples needed to assert alarm (legal range 1..15)
- OFF_COUNT, 2, consecutive valid ge=0 samples needed to deassert alarm (legal range 1..15)
- CNT_W, 8, width of the rise-event counter

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- valid  input  1  ge is a fresh sample this cycle
- ge  input  1  comparator result (D of the >= comparator)
- clear  input  1  synchronous clear of the event counter (and of the latch, see Optional Feature)
- alarm  output  1  debounced comparison result, registered
- rise  output  1  one-cycle pulse when alarm goes 0->1
- events  output  CNT_W  saturating count of alarm rises
- run_len  output  4  current consecutive-sample count inside ARM/REL; 0 in OFF/ON

Behaviour:
- Reset (rst=1, asynchronous):
  - state=OFF, alarm=0, rise=0, events=0, run_len=0.
  - Takes effect immediately, including mid-ARM or mid-REL; a partial run is discarded.
- FSM states: OFF, ARM, ON, REL. Only cycles with valid=1 advance the FSM. With valid=0, state, run_len and alarm hold, and rise=0.
- OFF:
  - valid&ge: if ON_COUNT==1, go to ON; else go to ARM with run_len=1.
  - valid&!ge: stay in OFF.
- ARM:
  - valid&ge: run_len+1. When it reaches ON_COUNT, go to ON with run_len=0.
  - valid&!ge: go to OFF with run_len=0. There is no partial credit.
- ON:
  - valid&!ge: if OFF_COUNT==1, go to OFF; else go to REL with run_len=1.
  - valid&ge: stay in ON.
- REL:
  - valid&!ge: run_len+1. When it reaches OFF_COUNT, go to OFF with run_len=0.
  - valid&ge: return to ON with run_len=0.
- Output timing:
  - alarm=1 in ON and REL, 0 in OFF and ARM.
  - alarm changes on the same edge that samples the qualifying valid beat, so it is visible one cycle after that beat.
- rise:
  - High for exactly the one cycle following each OFF/ARM->ON transition.
  - A REL->ON return does not pulse rise.
- events:
  - Increments by 1 on each rise and saturates at 2^CNT_W-1 (no wrap).
- clear:
  - Sets events=0 on the next edge.
  - If clear and a rise occur in the same cycle, clear wins: events=0 and that rise is not counted. The rise pulse itself still fires.
  - clear does not affect the FSM, except as described under Optional Feature.
- Parameter errors: ON_COUNT or OFF_COUNT of 0 or greater than 15 is a configuration error; the behaviour is not guaranteed.

Optional Feature:
- Macro: UMBRAL_LATCH_EN
- Defined:
  - Once alarm rises, it stays 1 and the FSM stays in ON, ignoring ge=0 samples and never entering REL, until clear=1.
  - clear then forces state=OFF, alarm=0, run_len=0 and events=0 on the next edge.
  - clear while not latched behaves as in the base block.
- Undefined: the hysteresis release path (ON->REL->OFF) operates as specified in Behaviour.

Test Plan:
- Reset: rst=1 asynchronously mid-cycle -> alarm=0, rise=0, events=0, run_len=0 immediately, without waiting for a clock edge.
- Arm: ON_COUNT=3, A=12, B=4 (ge=1) with valid on 3 consecutive cycles -> run_len 1,2 then alarm=1, rise=1 for one cycle, events=1.
- Broken arm: ge pattern 1,1,0,1,1,1 (all valid) -> alarm rises only after the 6th sample; run_len resets to 0 after the 0.
- Gaps: ge=1 with valid pattern 1,0,0,1,0,1 -> alarm rises after the third valid beat; alarm, state and run_len are unchanged on the valid=0 cycles.
- Hysteresis: from ON with OFF_COUNT=2, ge pattern 0,1,0,0 (A=3, B=4) -> REL, back to ON with no rise, then REL, then OFF with alarm=0; events unchanged.
- Saturation and clear: CNT_W=2, produce 5 rises -> events=3; assert clear on the same cycle as a 6th rise -> events=0 and rise=1. With UMBRAL_LATCH_EN defined: after a rise, ge=0 for 10 valid cycles -> alarm stays 1; clear -> alarm=0.
